// File: rtl/pacman_pkg.sv
// Shared constants and coordinate types for the pacman video path.
// Holds the game-map size, the 640x480@60 raster timing and the scaled window length helper.
package pacman_pkg;

  localparam int H_MAP_WIDTH  = 224;
  localparam int V_MAP_HEIGHT = 288;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  typedef logic [7:0] game_x_t;
  typedef logic [8:0] game_y_t;

  // Physical pixels needed to cover map_len game pixels at num/den game pixels per physical pixel.
  function automatic int scaled_len(int map_len, int num, int den);
    return (map_len * den + num - 1) / num;
  endfunction

endpackage

// File: rtl/scale_stepper.sv
// Fractional num/den coordinate stepper for one screen axis.
// State describes the current raster position; 'start' loads index 0 and 'en' gates every update.
module scale_stepper #(
  parameter int NUM            = 3,
  parameter int DEN            = 5,
  parameter int WIN_LEN        = 374,
  parameter int CW             = 8,
  parameter bit START_ON_RESET = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  output logic [CW-1:0] coord,
  output logic          stb,
  output logic          active
);

  localparam int AW = $clog2(DEN + NUM + 1);
  localparam int IW = $clog2(WIN_LEN + 1);

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [IW-1:0] idx;
  logic          last;

  assign sum  = acc + AW'(NUM);
  assign last = (idx == IW'(WIN_LEN - 1));

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // A window that starts at raster position 0 is already open when the counters sit at reset.
      acc    <= '0;
      idx    <= '0;
      coord  <= '0;
      stb    <= START_ON_RESET;
      active <= START_ON_RESET;
    end else if (en) begin
      if (start) begin
        acc    <= '0;
        idx    <= '0;
        coord  <= '0;
        stb    <= 1'b1;
        active <= 1'b1;
      end else if (active && !last) begin
        idx <= idx + IW'(1);
        if (sum >= AW'(DEN)) begin
          acc   <= sum - AW'(DEN);
          coord <= coord + CW'(1);
          stb   <= 1'b1;
        end else begin
          acc <= sum;
          stb <= 1'b0;
        end
      end else begin
        acc    <= '0;
        idx    <= '0;
        coord  <= '0;
        stb    <= 1'b0;
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/game_vga_timing.sv
// VGA raster generator producing game-map coordinates and strobes for pacman_game.
// Every output is registered one cycle behind the (hx,vy) counters it describes.
module game_vga_timing #(
  parameter int H_ACTIVE     = pacman_pkg::H_ACTIVE,
  parameter int H_FP         = pacman_pkg::H_FP,
  parameter int H_SYNC       = pacman_pkg::H_SYNC,
  parameter int H_BP         = pacman_pkg::H_BP,
  parameter int V_ACTIVE     = pacman_pkg::V_ACTIVE,
  parameter int V_FP         = pacman_pkg::V_FP,
  parameter int V_SYNC       = pacman_pkg::V_SYNC,
  parameter int V_BP         = pacman_pkg::V_BP,
  parameter int H_MAP_WIDTH  = pacman_pkg::H_MAP_WIDTH,
  parameter int V_MAP_HEIGHT = pacman_pkg::V_MAP_HEIGHT,
  parameter int SCALE_NUM    = 3,
  parameter int SCALE_DEN    = 5,
  parameter int H_OFFSET     = 133,
  parameter int V_OFFSET     = 0,
  parameter bit SYNC_POL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                hsync,
  output logic                vsync,
  output logic                video_active,
  output logic                display_enabled,
  output pacman_pkg::game_x_t sx,
  output pacman_pkg::game_y_t sy,
  output logic                game_pix_stb,
  output logic                frame_stb
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int H_WIN    = pacman_pkg::scaled_len(H_MAP_WIDTH, SCALE_NUM, SCALE_DEN);
  localparam int V_WIN    = pacman_pkg::scaled_len(V_MAP_HEIGHT, SCALE_NUM, SCALE_DEN);
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);

  if (SCALE_NUM > SCALE_DEN) begin : g_bad_scale
    $fatal(1, "game_vga_timing: SCALE_NUM must not exceed SCALE_DEN");
  end
  if (H_OFFSET + H_WIN > H_ACTIVE) begin : g_bad_h_window
    $fatal(1, "game_vga_timing: horizontal game window exceeds the active line");
  end
  if (V_OFFSET + V_WIN > V_ACTIVE) begin : g_bad_v_window
    $fatal(1, "game_vga_timing: vertical game window exceeds the active frame");
  end

  logic [HW-1:0]       hx, hx_next;
  logic [VW-1:0]       vy, vy_next;
  logic                line_end;
  pacman_pkg::game_x_t gx;
  pacman_pkg::game_y_t gy;
  logic                h_stb, h_win, v_stb, v_win;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    line_end = (hx == HW'(H_TOTAL - 1));
    hx_next  = line_end ? '0 : hx + HW'(1);
    vy_next  = vy;
    if (line_end) vy_next = (vy == VW'(V_TOTAL - 1)) ? '0 : vy + VW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hx <= '0;
      vy <= '0;
    end else begin
      hx <= hx_next;
      vy <= vy_next;
    end
  end

  // Steppers look one position ahead so their state matches the counters after each edge.
  scale_stepper #(
    .NUM(SCALE_NUM), .DEN(SCALE_DEN), .WIN_LEN(H_WIN),
    .CW($bits(pacman_pkg::game_x_t)), .START_ON_RESET(H_OFFSET == 0)
  ) u_h_stepper (
    .clk(clk), .rst(rst), .en(1'b1), .start(hx_next == HW'(H_OFFSET)),
    .coord(gx), .stb(h_stb), .active(h_win)
  );

  scale_stepper #(
    .NUM(SCALE_NUM), .DEN(SCALE_DEN), .WIN_LEN(V_WIN),
    .CW($bits(pacman_pkg::game_y_t)), .START_ON_RESET(V_OFFSET == 0)
  ) u_v_stepper (
    .clk(clk), .rst(rst), .en(line_end), .start(vy_next == VW'(V_OFFSET)),
    .coord(gy), .stb(v_stb), .active(v_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync           <= ~SYNC_POL;
      vsync           <= ~SYNC_POL;
      video_active    <= 1'b0;
      display_enabled <= 1'b0;
      sx              <= '0;
      sy              <= '0;
      game_pix_stb    <= 1'b0;
      frame_stb       <= 1'b0;
    end else begin
      hsync           <= (hx >= HW'(HS_START) && hx < HW'(HS_START + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
      vsync           <= (vy >= VW'(VS_START) && vy < VW'(VS_START + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
      video_active    <= (hx < HW'(H_ACTIVE)) && (vy < VW'(V_ACTIVE));
      display_enabled <= h_win && v_win;
      sx              <= gx;
      sy              <= gy;
      game_pix_stb    <= h_stb && v_win;
      // The first game row is the only one whose row strobe coincides with coordinate zero.
      frame_stb       <= h_stb && v_stb && v_win && (gx == '0) && (gy == '0);
    end
  end

endmodule

// File: tb/tb_game_vga_timing.sv
// Scoreboard bench for game_vga_timing: default, alternate-scale and compact-raster instances.
// Expected strobes are queued from a multiply-based model; a negedge monitor pops and compares.
module tb_game_vga_timing;

  typedef struct {
    logic hs, vs, va, de, stb, frm;
    int   sx, sy;
  } exp_t;

  typedef struct {
    int hx, vy, sx, sy;
    bit frm;
  } sb_ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_c = 1'b1;
  always #5 clk = ~clk;

  logic       d_hsync, d_vsync, d_va, d_de, d_stb, d_frm;
  logic [7:0] d_sx;
  logic [8:0] d_sy;
  logic       v_hsync, v_vsync, v_va, v_de, v_stb, v_frm;
  logic [7:0] v_sx;
  logic [8:0] v_sy;
  logic       c_hsync, c_vsync, c_va, c_de, c_stb, c_frm;
  logic [7:0] c_sx;
  logic [8:0] c_sy;

  game_vga_timing u_dut (
    .clk(clk), .rst(rst), .hsync(d_hsync), .vsync(d_vsync), .video_active(d_va),
    .display_enabled(d_de), .sx(d_sx), .sy(d_sy), .game_pix_stb(d_stb), .frame_stb(d_frm)
  );

  game_vga_timing #(
    .SCALE_NUM(2), .SCALE_DEN(3), .H_OFFSET(152), .V_OFFSET(24)
  ) u_dut_var (
    .clk(clk), .rst(rst), .hsync(v_hsync), .vsync(v_vsync), .video_active(v_va),
    .display_enabled(v_de), .sx(v_sx), .sy(v_sy), .game_pix_stb(v_stb), .frame_stb(v_frm)
  );

  // Minimal raster: 232 clocks per line, 292 lines, 1:1 mapping filling the whole active area.
  game_vga_timing #(
    .H_ACTIVE(224), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(288), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SCALE_NUM(1), .SCALE_DEN(1), .H_OFFSET(0), .V_OFFSET(0)
  ) u_dut_cmp (
    .clk(clk), .rst(rst_c), .hsync(c_hsync), .vsync(c_vsync), .video_active(c_va),
    .display_enabled(c_de), .sx(c_sx), .sy(c_sy), .game_pix_stb(c_stb), .frame_stb(c_frm)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected outputs for a raster position, derived from the closed-form floor(i*num/den).
  function automatic exp_t model(input int pos, input int num, input int den, input int ho, input int vo);
    exp_t e;
    int hx = pos % 800;
    int vy = (pos / 800) % 525;
    int hl = (224 * den + num - 1) / num;
    int vl = (288 * den + num - 1) / num;
    int i  = hx - ho;
    int j  = vy - vo;
    bit hw = (i >= 0) && (i < hl);
    bit vw = (j >= 0) && (j < vl);
    e.hs  = !(hx >= 656 && hx < 752);
    e.vs  = !(vy >= 490 && vy < 492);
    e.va  = (hx < 640) && (vy < 480);
    e.de  = hw && vw;
    e.sx  = hw ? (i * num) / den : 0;
    e.sy  = vw ? (j * num) / den : 0;
    e.stb = e.de && ((i == 0) || ((i * num) / den != ((i - 1) * num) / den));
    e.frm = e.stb && (i == 0) && (j == 0);
    return e;
  endfunction

  sb_ent_t sb_d[$];
  sb_ent_t sb_v[$];

  task automatic push_lines(input bit var_sel, input int l0, input int l1);
    for (int vy = l0; vy <= l1; vy++) begin
      for (int hx = 0; hx < 800; hx++) begin
        exp_t    e;
        sb_ent_t s;
        e = var_sel ? model(vy * 800 + hx, 2, 3, 152, 24) : model(vy * 800 + hx, 3, 5, 133, 0);
        if (e.stb) begin
          s.hx = hx; s.vy = vy; s.sx = e.sx; s.sy = e.sy; s.frm = e.frm;
          if (var_sel) sb_v.push_back(s);
          else         sb_d.push_back(s);
        end
      end
    end
  endtask

  task automatic level_checks(input string tag, input exp_t e, input logic hs, input logic vs,
                              input logic va, input logic de, input int sx, input int sy);
    check({tag, "_hsync"}, hs, e.hs);
    check({tag, "_vsync"}, vs, e.vs);
    check({tag, "_video_active"}, va, e.va);
    check({tag, "_display_enabled"}, de, e.de);
    check({tag, "_sx"}, sx, e.sx);
    check({tag, "_sy"}, sy, e.sy);
  endtask

  task automatic cmp_ent(input string tag, input sb_ent_t s, input int pos, input int sx,
                         input int sy, input logic frm);
    check({tag, "_stb_hx"}, pos % 800, s.hx);
    check({tag, "_stb_vy"}, pos / 800, s.vy);
    check({tag, "_stb_sx"}, sx, s.sx);
    check({tag, "_stb_sy"}, sy, s.sy);
    check({tag, "_stb_frame"}, frm, s.frm);
  endtask

  task automatic check_reset(input string tag, input logic hs, input logic vs, input logic va,
                             input logic de, input logic stb, input logic frm, input int sx, input int sy);
    check({tag, "_rst_hsync"}, hs, 1);
    check({tag, "_rst_vsync"}, vs, 1);
    check({tag, "_rst_video_active"}, va, 0);
    check({tag, "_rst_display_enabled"}, de, 0);
    check({tag, "_rst_game_pix_stb"}, stb, 0);
    check({tag, "_rst_frame_stb"}, frm, 0);
    check({tag, "_rst_sx"}, sx, 0);
    check({tag, "_rst_sy"}, sy, 0);
  endtask

  // Bench-side raster position: ctr_* is the counter value, desc_* the position the outputs describe.
  int ctr_d = 0, desc_d = 0, ctr_c = 0, desc_c = 0;
  bit vld_d = 1'b0, vld_c = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ctr_d <= 0;
      vld_d <= 1'b0;
    end else begin
      desc_d <= ctr_d;
      ctr_d  <= ctr_d + 1;
      vld_d  <= 1'b1;
    end
    if (rst_c) begin
      ctr_c <= 0;
      vld_c <= 1'b0;
    end else begin
      desc_c <= ctr_c;
      ctr_c  <= ctr_c + 1;
      vld_c  <= 1'b1;
    end
  end

  int d_l0_stb, d_l0_de, d_frm_cyc, v_l24_stb, v_l24_de, v_frm_cyc;
  int c_frm_cnt = 0, c_frm1 = -1, c_frm2 = -1, c_vs_cnt = 0, c_vs_first = -1, c_de_cnt = 0;

  always @(negedge clk) begin
    if (vld_d) begin
      level_checks("d", model(desc_d, 3, 5, 133, 0), d_hsync, d_vsync, d_va, d_de, d_sx, d_sy);
      if (d_stb) begin
        if (sb_d.size() == 0) check("d_stb_unexpected", 1, 0);
        else cmp_ent("d", sb_d.pop_front(), desc_d, d_sx, d_sy, d_frm);
      end else check("d_frame_without_stb", d_frm, 0);
      if (desc_d < 800) begin
        d_l0_stb += d_stb;
        d_l0_de  += d_de;
      end
      if (d_frm && d_frm_cyc < 0) d_frm_cyc = desc_d + 1;
    end else begin
      d_l0_stb = 0; d_l0_de = 0; d_frm_cyc = -1;
    end

    if (vld_d) begin
      level_checks("v", model(desc_d, 2, 3, 152, 24), v_hsync, v_vsync, v_va, v_de, v_sx, v_sy);
      if (v_stb) begin
        if (sb_v.size() == 0) check("v_stb_unexpected", 1, 0);
        else cmp_ent("v", sb_v.pop_front(), desc_d, v_sx, v_sy, v_frm);
      end else check("v_frame_without_stb", v_frm, 0);
      if (desc_d / 800 == 24) begin
        v_l24_stb += v_stb;
        v_l24_de  += v_de;
      end
      if (v_frm && v_frm_cyc < 0) v_frm_cyc = desc_d + 1;
    end else begin
      v_l24_stb = 0; v_l24_de = 0; v_frm_cyc = -1;
    end

    if (vld_c) begin
      if (c_frm) begin
        c_frm_cnt++;
        if (c_frm_cnt == 1) c_frm1 = desc_c + 1;
        if (c_frm_cnt == 2) c_frm2 = desc_c + 1;
      end
      if (desc_c < 67744) begin
        if (!c_vsync) begin
          c_vs_cnt++;
          if (c_vs_first < 0) c_vs_first = desc_c;
        end
        c_de_cnt += c_de;
      end
    end
  end

  initial begin
    int guard;
    // Reset held for four edges.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset("d", d_hsync, d_vsync, d_va, d_de, d_stb, d_frm, d_sx, d_sy);
    check_reset("c", c_hsync, c_vsync, c_va, c_de, c_stb, c_frm, c_sx, c_sy);
    push_lines(1'b0, 0, 25);
    push_lines(1'b1, 0, 25);
    rst   = 1'b0;
    rst_c = 1'b0;

    // Run to counter position (hx=300, vy=25), then reset mid-frame.
    guard = 0;
    while (ctr_d != 25 * 800 + 300 && guard < 30000) begin
      @(negedge clk);
      guard++;
    end
    check("mid_reset_point_reached", ctr_d, 25 * 800 + 300);
    #1;
    check("d_first_frame_cycles", d_frm_cyc, 134);
    check("v_first_frame_cycles", v_frm_cyc, 24 * 800 + 152 + 1);
    check("d_line0_strobes", d_l0_stb, 224);
    check("d_line0_window", d_l0_de, 374);
    check("v_line24_strobes", v_l24_stb, 224);
    check("v_line24_window", v_l24_de, 336);
    check("d_sb_no_missed_pre_reset", (sb_d.size() > 0) && (sb_d[0].vy * 800 + sb_d[0].hx >= 20300), 1);
    check("v_sb_no_missed_pre_reset", (sb_v.size() > 0) && (sb_v[0].vy * 800 + sb_v[0].hx >= 20300), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("d_mid", d_hsync, d_vsync, d_va, d_de, d_stb, d_frm, d_sx, d_sy);
    check_reset("v_mid", v_hsync, v_vsync, v_va, v_de, v_stb, v_frm, v_sx, v_sy);
    sb_d.delete();
    sb_v.delete();
    push_lines(1'b0, 0, 99);
    push_lines(1'b1, 0, 99);
    rst = 1'b0;

    // Keep scanning until the compact raster shows its second frame.
    guard = 0;
    while (c_frm_cnt < 2 && guard < 80000) begin
      @(negedge clk);
      guard++;
    end
    check("c_second_frame_seen", c_frm_cnt >= 2, 1);
    #1;
    check("d_frame_cycles_after_reset", d_frm_cyc, 134);
    check("v_frame_cycles_after_reset", v_frm_cyc, 24 * 800 + 152 + 1);
    check("d_line0_strobes_after_reset", d_l0_stb, 224);
    check("d_sb_no_missed_end", (sb_d.size() > 0) && (sb_d[0].vy * 800 + sb_d[0].hx > desc_d), 1);
    check("v_sb_no_missed_end", (sb_v.size() > 0) && (sb_v[0].vy * 800 + sb_v[0].hx > desc_d), 1);
    check("c_first_frame_cycles", c_frm1, 1);
    check("c_frame_period", c_frm2 - c_frm1, 232 * 292);
    check("c_vsync_low_cycles", c_vs_cnt, 2 * 232);
    check("c_vsync_first_pos", c_vs_first, 289 * 232);
    check("c_window_cycles", c_de_cnt, 224 * 288);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
